// File: rtl/traffic_pkg.sv
// Shared constants and light-state encoding for the traffic-light controller
// and its timer responder.
package traffic_pkg;

  localparam int SHORT_CNT_DEF = 2;
  localparam int LONG_CNT_DEF  = 10;
  localparam int CNT_W_DEF     = 4;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_GREEN  = 2'd1,
    LIGHT_YELLOW = 2'd2
  } light_e;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter: advances on INC, wraps to 0 after N-1 and flags the wrap
// combinationally so the parent can register its own terminal-count pulse.
module mod_n_counter #(
  parameter int N = 2,
  parameter int W = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q,
  output logic         WRAP
);

  // Using >= keeps the counter bounded even if it ever sits above N-1.
  assign WRAP = INC && (Q >= W'(N - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= '0;
    end else if (CLR) begin
      Q <= '0;
    end else if (WRAP) begin
      Q <= '0;
    end else if (INC) begin
      Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Timer responder for the traffic-light FSM: prescaled short/long terminal-count
// pulses. Define TRAFFIC_TIMER_STICKY_EN to make TC_2/TC_10 sticky until cleared.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int SHORT_CNT = SHORT_CNT_DEF,
  parameter int LONG_CNT  = LONG_CNT_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_W     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RST_Q,
  input  logic             EN,
  output logic             TC_2,
  output logic             TC_10,
  output logic [CNT_W-1:0] Q2,
  output logic [CNT_W-1:0] Q10,
  output logic             TICK
);

  logic [DIV_W-1:0] prescale;
  logic             tick;
  logic             wrap_short;
  logic             wrap_long;

  assign tick = EN && (prescale == DIV_W'(CLK_DIV - 1));

  // TICK follows tick directly; tick is already low whenever EN is low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescale <= '0;
      TICK     <= 1'b0;
    end else if (RST_Q) begin
      prescale <= '0;
      TICK     <= 1'b0;
    end else begin
      TICK <= tick;
      if (EN) begin
        prescale <= tick ? '0 : prescale + 1'b1;
      end
    end
  end

  mod_n_counter #(
    .N (SHORT_CNT),
    .W (CNT_W)
  ) u_short (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (RST_Q),
    .INC   (tick),
    .Q     (Q2),
    .WRAP  (wrap_short)
  );

  mod_n_counter #(
    .N (LONG_CNT),
    .W (CNT_W)
  ) u_long (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (RST_Q),
    .INC   (tick),
    .Q     (Q10),
    .WRAP  (wrap_long)
  );

  // A clear on the same edge as a wrap suppresses the pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TC_2  <= 1'b0;
      TC_10 <= 1'b0;
    end else if (RST_Q) begin
      TC_2  <= 1'b0;
      TC_10 <= 1'b0;
    end else begin
`ifdef TRAFFIC_TIMER_STICKY_EN
      TC_2  <= TC_2 | wrap_short;
      TC_10 <= TC_10 | wrap_long;
`else
      TC_2  <= wrap_short;
      TC_10 <= wrap_long;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer: default instance plus a CLK_DIV=4 instance,
// both compared against an edge-count model; honours TRAFFIC_TIMER_STICKY_EN.
module tb_traffic_timer;

`ifdef TRAFFIC_TIMER_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rst_q;
  logic       en;
  logic       tc_2_a, tc_10_a, tick_a;
  logic [3:0] q2_a, q10_a;
  logic       tc_2_b, tc_10_b, tick_b;
  logic [3:0] q2_b, q10_b;

  int vectors;
  int miscompares;

  int n;
  bit counted;
  bit s2a, s10a, s2b, s10b;

  typedef struct {
    bit rq;
    bit e;
    int q2;
    int q10;
    bit tc10;
  } vec_t;

  vec_t table_v[12];

  traffic_timer dut_a (
    .CLK   (clk),
    .RST_N (rst_n),
    .RST_Q (rst_q),
    .EN    (en),
    .TC_2  (tc_2_a),
    .TC_10 (tc_10_a),
    .Q2    (q2_a),
    .Q10   (q10_a),
    .TICK  (tick_a)
  );

  traffic_timer #(
    .CLK_DIV (4)
  ) dut_b (
    .CLK   (clk),
    .RST_N (rst_n),
    .RST_Q (rst_q),
    .EN    (en),
    .TC_2  (tc_2_b),
    .TC_10 (tc_10_b),
    .Q2    (q2_b),
    .Q10   (q10_b),
    .TICK  (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The model counts enabled edges since the last clear; every output is
  // derived from that count with division and modulo.
  function automatic bit wraps(input int nn, input int div, input int cnt);
    return (nn > 0) && (nn % div == 0) && ((nn / div) % cnt == 0);
  endfunction

  function automatic int exp_tick(input int div);
    return (counted && (n % div == 0)) ? 1 : 0;
  endfunction

  function automatic int exp_q(input int div, input int cnt);
    return (n / div) % cnt;
  endfunction

  function automatic int exp_tc(input int div, input int cnt, input bit s);
    if (STICKY) return s ? 1 : 0;
    return (counted && wraps(n, div, cnt)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    n = 0;
    counted = 0;
    s2a = 0; s10a = 0; s2b = 0; s10b = 0;
  endtask

  task automatic update_model(input bit rq, input bit e);
    if (rq) begin
      model_reset();
    end else if (e) begin
      n++;
      counted = 1;
      s2a  = s2a  | wraps(n, 1, 2);
      s10a = s10a | wraps(n, 1, 10);
      s2b  = s2b  | wraps(n, 4, 2);
      s10b = s10b | wraps(n, 4, 10);
    end else begin
      counted = 0;
    end
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all();
    check_output("tick_a", tick_a, exp_tick(1));
    check_output("q2_a", q2_a, exp_q(1, 2));
    check_output("q10_a", q10_a, exp_q(1, 10));
    check_output("tc2_a", tc_2_a, exp_tc(1, 2, s2a));
    check_output("tc10_a", tc_10_a, exp_tc(1, 10, s10a));
    check_output("tick_b", tick_b, exp_tick(4));
    check_output("q2_b", q2_b, exp_q(4, 2));
    check_output("q10_b", q10_b, exp_q(4, 10));
    check_output("tc2_b", tc_2_b, exp_tc(4, 2, s2b));
    check_output("tc10_b", tc_10_b, exp_tc(4, 10, s10b));
  endtask

  task automatic apply_stimulus(input bit rq, input bit e);
    rst_q = rq;
    en    = e;
    @(posedge clk);
    update_model(rq, e);
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int first_tick, first_tc2, first_tc10;
    bit found;

    vectors = 0;
    miscompares = 0;

    for (int i = 0; i < 10; i++) begin
      table_v[i].rq   = 1'b0;
      table_v[i].e    = 1'b1;
      table_v[i].q2   = (i + 1) % 2;
      table_v[i].q10  = (i + 1) % 10;
      table_v[i].tc10 = (i == 9);
    end
    table_v[10].rq = 1'b1; table_v[10].e = 1'b1;
    table_v[10].q2 = 0; table_v[10].q10 = 0; table_v[10].tc10 = 1'b0;
    table_v[11].rq = 1'b0; table_v[11].e = 1'b0;
    table_v[11].q2 = 0; table_v[11].q10 = 0; table_v[11].tc10 = 1'b0;

    rst_n = 1'b0;
    rst_q = 1'b0;
    en    = 1'b0;
    model_reset();
    #23;
    check_all();
    en = 1'b1;
    #10;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] table vectors, defaults from reset release");
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(table_v[i].rq, table_v[i].e);
      check_output("tbl_q2", q2_a, table_v[i].q2);
      check_output("tbl_q10", q10_a, table_v[i].q10);
      check_output("tbl_tc10", tc_10_a, table_v[i].tc10);
    end

    $display("[TB] clear mid-count at Q10=6");
    apply_stimulus(1, 0);
    for (int k = 0; k < 6; k++) apply_stimulus(0, 1);
    check_output("pre_clear_q10", q10_a, 6);
    apply_stimulus(1, 1);
    check_output("clear_q10", q10_a, 0);
    check_output("clear_q2", q2_a, 0);
    lat = 0;
    found = 0;
    for (int k = 1; k <= 30 && !found; k++) begin
      apply_stimulus(0, 1);
      if (tc_10_a) begin
        found = 1;
        lat = k;
        check_output("simultaneous_wrap_tc2", tc_2_a, 1);
      end
    end
    check_output("clear_latency", lat, 10);

    $display("[TB] EN dropped at Q10=4");
    apply_stimulus(1, 0);
    for (int k = 0; k < 4; k++) apply_stimulus(0, 1);
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(0, 0);
      check_output("hold_q10", q10_a, 4);
      check_output("hold_tc10", tc_10_a, 0);
    end
    lat = 0;
    found = 0;
    for (int k = 1; k <= 30 && !found; k++) begin
      apply_stimulus(0, 1);
      if (tc_10_a) begin
        found = 1;
        lat = k;
      end
    end
    check_output("resume_latency", lat, 6);

    $display("[TB] clear on a wrap edge");
    apply_stimulus(1, 0);
    for (int k = 0; k < 9; k++) apply_stimulus(0, 1);
    apply_stimulus(1, 1);
    check_output("clear_beats_wrap", tc_10_a, 0);

    $display("[TB] CLK_DIV=4 timing");
    apply_stimulus(1, 0);
    first_tick = 0;
    first_tc2 = 0;
    first_tc10 = 0;
    for (int k = 1; k <= 60; k++) begin
      apply_stimulus(0, 1);
      if (tick_b && first_tick == 0) first_tick = k;
      if (tc_2_b && first_tc2 == 0) first_tc2 = k;
      if (tc_10_b && first_tc10 == 0) first_tc10 = k;
    end
    check_output("div4_first_tick", first_tick, 4);
    check_output("div4_first_tc2", first_tc2, 8);
    check_output("div4_first_tc10", first_tc10, 40);

    $display("[TB] async reset while TC_10 high");
    apply_stimulus(1, 0);
    for (int k = 0; k < 10; k++) apply_stimulus(0, 1);
    check_output("pre_async_tc10", tc_10_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_tc10", tc_10_a, 0);
    check_output("async_q10", q10_a, 0);
    check_output("async_q2", q2_a, 0);
    check_output("async_q10_b", q10_b, 0);
    model_reset();
    #2;
    rst_n = 1'b1;

`ifdef TRAFFIC_TIMER_STICKY_EN
    $display("[TB] sticky flags with EN toggling");
    apply_stimulus(1, 0);
    for (int k = 1; k <= 10; k++) apply_stimulus(0, 1);
    check_output("sticky_rise", tc_10_a, 1);
    for (int k = 11; k <= 25; k++) begin
      apply_stimulus(0, k % 2);
      check_output("sticky_hold", tc_10_a, 1);
    end
    apply_stimulus(1, 0);
    check_output("sticky_clear", tc_10_a, 0);
`endif

    $display("[TB] randomized stimulus");
    for (int k = 0; k < 400; k++) begin
      apply_stimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
